// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC frame UART transmitter.
package adc_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  localparam int unsigned FRAME_BYTES    = 6;
  localparam logic [7:0]  DEFAULT_HEADER = 8'hA5;

  // Sum of the four channel bytes, wrapped to 8 bits; the header is not included.
  function automatic logic [7:0] checksum8(input logic [7:0] c0, input logic [7:0] c1,
                                           input logic [7:0] c2, input logic [7:0] c3);
    logic [9:0] sum;
    sum = 10'(c0) + 10'(c1) + 10'(c2) + 10'(c3);
    return 8'(sum);
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first. A start request in the final stop-bit cycle chains
// the next byte with no idle gap.
module uart_tx_byte
  import adc_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] data,
  output logic       TX,
  output logic       byte_done
);

  localparam int unsigned   CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q;
  logic [CW-1:0] baud_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    data_q;
  logic          baud_end;
  logic [2:0]    bit_nxt;

  assign baud_end  = (baud_cnt_q == BAUD_LAST);
  assign bit_nxt   = bit_idx_q + 3'd1;
  // Last cycle of the stop bit; a function of registers only.
  assign byte_done = (state_q == STOP) && baud_end;

  // Bit-timing FSM with registered serial output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      data_q     <= '0;
      TX         <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          baud_cnt_q <= '0;
          bit_idx_q  <= '0;
          TX         <= 1'b1;
          if (start) begin
            data_q  <= data;
            TX      <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            TX         <= data_q[0];
            state_q    <= DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
              TX        <= 1'b1;
              state_q   <= STOP;
            end else begin
              bit_idx_q <= bit_nxt;
              TX        <= data_q[bit_nxt];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt_q <= '0;
            if (start) begin
              data_q  <= data;
              TX      <= 1'b0;
              state_q <= START;
            end else begin
              TX      <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/adc_frame_uart_tx.sv
// Snapshots four ADC channel results on each rise of done and sends them as a
// 6-byte UART frame: header, ch0..ch3, checksum.
module adc_frame_uart_tx
  import adc_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter logic [7:0]  HEADER       = DEFAULT_HEADER
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       done,
  input  logic [7:0] ch0,
  input  logic [7:0] ch1,
  input  logic [7:0] ch2,
  input  logic [7:0] ch3,
  output logic       TX,
  output logic       busy,
  output logic       frame_sent,
  output logic       overrun
);

  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

  logic       s1_q, s2_q, s3_q;
  logic       primed_q, armed_q;
  logic [7:0] ch0_q, ch1_q, ch2_q, ch3_q, csum_q;
  logic [2:0] byte_idx_q;
  logic       rise, byte_done, frame_end, accept, next_byte, byte_start;
  logic [7:0] byte_data;

  // armed_q requires a genuine low sample after reset, so a done held high across
  // reset does not look like a fresh rise.
  assign rise       = s2_q & ~s3_q & armed_q;
  assign frame_end  = byte_done && (byte_idx_q == LAST_BYTE);
  assign accept     = rise && (!busy || frame_end);
  assign next_byte  = byte_done && (byte_idx_q != LAST_BYTE);
  assign byte_start = accept || next_byte;

  // Byte to load on the next start: header for a new frame, else the following snapshot byte.
  always_comb begin
    byte_data = HEADER;
    if (!accept) begin
      case (byte_idx_q)
        3'd0:    byte_data = ch0_q;
        3'd1:    byte_data = ch1_q;
        3'd2:    byte_data = ch2_q;
        3'd3:    byte_data = ch3_q;
        3'd4:    byte_data = csum_q;
        default: byte_data = HEADER;
      endcase
    end
  end

  // done synchronizer, edge-detect history and post-reset arming.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      primed_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      s1_q     <= done;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      primed_q <= 1'b1;
      armed_q  <= armed_q | (primed_q & ~s1_q);
    end
  end

  // Frame sequencing: snapshot, byte index, busy and status pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ch0_q      <= '0;
      ch1_q      <= '0;
      ch2_q      <= '0;
      ch3_q      <= '0;
      csum_q     <= '0;
      byte_idx_q <= '0;
      busy       <= 1'b0;
      frame_sent <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_sent <= frame_end;
      overrun    <= rise && busy && !frame_end;
      if (accept) begin
        ch0_q      <= ch0;
        ch1_q      <= ch1;
        ch2_q      <= ch2;
        ch3_q      <= ch3;
        csum_q     <= checksum8(ch0, ch1, ch2, ch3);
        byte_idx_q <= '0;
        busy       <= 1'b1;
      end else if (frame_end) begin
        byte_idx_q <= '0;
        busy       <= 1'b0;
      end else if (next_byte) begin
        byte_idx_q <= byte_idx_q + 3'd1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .CLK      (CLK),
    .RST      (RST),
    .start    (byte_start),
    .data     (byte_data),
    .TX       (TX),
    .byte_done(byte_done)
  );

endmodule

// File: tb/tb_adc_frame_uart_tx.sv
// Bench for adc_frame_uart_tx: frame-level timing model, mid-bit UART receiver,
// directed scenarios and randomized done/reset traffic.
module tb_adc_frame_uart_tx;

  localparam int C         = 4;
  localparam int FRAME_CYC = 60 * C;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       done = 1'b0;
  logic [7:0] ch0 = 8'h00, ch1 = 8'h00, ch2 = 8'h00, ch3 = 8'h00;
  logic       TX, busy, frame_sent, overrun;

  adc_frame_uart_tx #(
    .CLKS_PER_BIT(C),
    .HEADER      (8'hA5)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .done      (done),
    .ch0       (ch0),
    .ch1       (ch1),
    .ch2       (ch2),
    .ch3       (ch3),
    .TX        (TX),
    .busy      (busy),
    .frame_sent(frame_sent),
    .overrun   (overrun)
  );

  always #5 CLK = ~CLK;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  bit chk_en = 1'b0;

  // Model state: done samples at the last three edges (2 = no valid sample since reset).
  int         h1 = 2, h2 = 2, h3 = 2;
  bit         m_active = 1'b0;
  int         m_t0 = 0;
  logic [7:0] m_bytes [6];
  logic       m_tx = 1'b1, m_busy = 1'b0, m_fs = 1'b0, m_ov = 1'b0;

  // Receiver and event counters.
  logic [7:0] rx_q [$];
  bit         rx_act = 1'b0;
  logic       rx_prev = 1'b1;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;
  int         fs_cnt = 0, ov_cnt = 0, busy_cyc = 0, busy_fall = 0;
  logic       prev_busy = 1'b0;

  task automatic model_tick();
    bit rise;
    int off, bi, ph, sum;
    m_fs = 1'b0;
    m_ov = 1'b0;
    if (RST) begin
      h1 = 2; h2 = 2; h3 = 2;
      m_active = 1'b0;
    end else begin
      // Edge k samples done=1 (k-1 sampled 0) -> accept at edge k+2.
      rise = (h2 == 1) && (h3 == 0);
      h3 = h2; h2 = h1; h1 = done ? 1 : 0;
      if (m_active && cyc == m_t0 + FRAME_CYC) begin
        m_active = 1'b0;
        m_fs     = 1'b1;
      end
      if (rise && !m_active) begin
        m_active   = 1'b1;
        m_t0       = cyc;
        m_bytes[0] = 8'hA5;
        m_bytes[1] = ch0;
        m_bytes[2] = ch1;
        m_bytes[3] = ch2;
        m_bytes[4] = ch3;
        sum        = int'(ch0) + int'(ch1) + int'(ch2) + int'(ch3);
        m_bytes[5] = 8'(sum % 256);
      end else if (rise) begin
        m_ov = 1'b1;
      end
    end
    m_busy = m_active;
    if (m_active) begin
      off = cyc - m_t0;
      bi  = off / (10 * C);
      ph  = (off % (10 * C)) / C;
      if (ph == 0)      m_tx = 1'b0;
      else if (ph == 9) m_tx = 1'b1;
      else              m_tx = m_bytes[bi][ph-1];
    end else begin
      m_tx = 1'b1;
    end
  endtask

  task automatic rx_tick();
    int idx;
    if (RST) begin
      rx_act  = 1'b0;
      rx_prev = 1'b1;
    end else begin
      if (!rx_act) begin
        if (rx_prev && !TX) begin
          rx_act = 1'b1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
      end
      if (rx_act) begin
        idx = rx_cnt / C;
        if ((rx_cnt % C) == C / 2 && idx >= 1 && idx <= 8) rx_sh[idx-1] = TX;
        if (rx_cnt == 10 * C - 1) begin
          rx_act = 1'b0;
          rx_q.push_back(rx_sh);
        end
      end
      rx_prev = TX;
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b want %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: advance the model at the edge, compare and observe at the falling edge.
  task automatic step();
    @(posedge CLK);
    cyc++;
    model_tick();
    @(negedge CLK);
    if (chk_en) begin
      chk1("TX", TX, m_tx);
      chk1("busy", busy, m_busy);
      chk1("frame_sent", frame_sent, m_fs);
      chk1("overrun", overrun, m_ov);
      rx_tick();
      if (frame_sent) fs_cnt++;
      if (overrun) ov_cnt++;
      if (busy) busy_cyc++;
      if (prev_busy && !busy) busy_fall++;
      prev_busy = busy;
    end
  endtask

  task automatic pulse_done(input int n);
    done = 1'b1;
    repeat (n) step();
    done = 1'b0;
  endtask

  task automatic wait_fs(input int target, input int budget, input string nm);
    int n;
    n = 0;
    while (fs_cnt < target && n < budget) begin
      step();
      n++;
    end
    chk_int({nm, " frame_sent before timeout"}, fs_cnt, target);
  endtask

  task automatic check_frame(input string nm, input int start, input logic [7:0] e [6]);
    logic [7:0] got;
    for (int i = 0; i < 6; i++) begin
      got = (start + i < rx_q.size()) ? rx_q[start+i] : 8'hxx;
      chk8($sformatf("%s rx byte %0d", nm, i), got, e[i]);
    end
  endtask

  initial begin
    logic [7:0] e [6];
    int q0, fs0, ov0, bc0, bf0, t0;

    // Reset
    RST = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    step();
    chk1("reset TX", TX, 1'b1);
    chk1("reset busy", busy, 1'b0);
    chk1("reset frame_sent", frame_sent, 1'b0);
    chk1("reset overrun", overrun, 1'b0);
    RST = 1'b0;
    repeat (5) step();

    // 1: basic frame
    q0 = rx_q.size(); fs0 = fs_cnt; bc0 = busy_cyc;
    ch0 = 8'h10; ch1 = 8'h20; ch2 = 8'h30; ch3 = 8'h40;
    pulse_done(8);
    wait_fs(fs0 + 1, 400, "t1");
    repeat (10) step();
    e = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};
    check_frame("t1", q0, e);
    chk_int("t1 rx byte count", rx_q.size() - q0, 6);
    chk_int("t1 busy cycles", busy_cyc - bc0, 240);
    chk_int("t1 frame_sent pulses", fs_cnt - fs0, 1);

    // 2: checksum wrap
    q0 = rx_q.size(); fs0 = fs_cnt;
    ch0 = 8'hFF; ch1 = 8'hFF; ch2 = 8'h01; ch3 = 8'h02;
    pulse_done(3);
    wait_fs(fs0 + 1, 400, "t2");
    repeat (10) step();
    e = '{8'hA5, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h01};
    check_frame("t2", q0, e);

    // 3: rise 50 cycles into a frame -> overrun only
    q0 = rx_q.size(); fs0 = fs_cnt; ov0 = ov_cnt;
    ch0 = 8'h5A; ch1 = 8'h3C; ch2 = 8'h11; ch3 = 8'h22;
    pulse_done(8);
    t0 = m_t0;
    while (cyc < t0 + 48) step();
    pulse_done(4);
    wait_fs(fs0 + 1, 400, "t3");
    repeat (300) step();
    e = '{8'hA5, 8'h5A, 8'h3C, 8'h11, 8'h22, 8'hC9};
    check_frame("t3", q0, e);
    chk_int("t3 overrun pulses", ov_cnt - ov0, 1);
    chk_int("t3 frame_sent pulses", fs_cnt - fs0, 1);
    chk_int("t3 rx byte count", rx_q.size() - q0, 6);

    // 4: accept lands in the final stop cycle -> back-to-back frames
    q0 = rx_q.size(); fs0 = fs_cnt; ov0 = ov_cnt; bf0 = busy_fall;
    ch0 = 8'h01; ch1 = 8'h80; ch2 = 8'h7F; ch3 = 8'hC3;
    pulse_done(8);
    t0 = m_t0;
    while (cyc < t0 + 237) step();
    done = 1'b1;
    repeat (6) step();
    done = 1'b0;
    wait_fs(fs0 + 2, 700, "t4");
    repeat (10) step();
    e = '{8'hA5, 8'h01, 8'h80, 8'h7F, 8'hC3, 8'hC3};
    check_frame("t4 frame1", q0, e);
    check_frame("t4 frame2", q0 + 6, e);
    chk_int("t4 rx byte count", rx_q.size() - q0, 12);
    chk_int("t4 frame_sent pulses", fs_cnt - fs0, 2);
    chk_int("t4 overrun pulses", ov_cnt - ov0, 0);
    chk_int("t4 busy falls", busy_fall - bf0, 1);

    // 5: reset in DATA of byte 2, then a clean frame
    fs0 = fs_cnt;
    ch0 = 8'h01; ch1 = 8'h02; ch2 = 8'h03; ch3 = 8'h04;
    pulse_done(4);
    t0 = m_t0;
    while (cyc < t0 + 93) step();
    RST = 1'b1;
    step();
    chk1("t5 TX after reset", TX, 1'b1);
    chk1("t5 busy after reset", busy, 1'b0);
    RST = 1'b0;
    repeat (300) step();
    chk_int("t5 no frame_sent after reset", fs_cnt - fs0, 0);
    q0 = rx_q.size();
    pulse_done(4);
    wait_fs(fs0 + 1, 400, "t5");
    repeat (10) step();
    e = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    check_frame("t5", q0, e);

    // 6: done held high -> one frame; low then high -> another
    q0 = rx_q.size(); fs0 = fs_cnt;
    ch0 = 8'h77; ch1 = 8'h88; ch2 = 8'h99; ch3 = 8'hAA;
    done = 1'b1;
    repeat (1000) step();
    chk_int("t6 frames while held", fs_cnt - fs0, 1);
    chk_int("t6 rx bytes while held", rx_q.size() - q0, 6);
    done = 1'b0;
    repeat (4) step();
    done = 1'b1;
    wait_fs(fs0 + 2, 400, "t6");
    done = 1'b0;
    repeat (10) step();
    e = '{8'hA5, 8'h77, 8'h88, 8'h99, 8'hAA, 8'h42};
    check_frame("t6 frame2", q0 + 6, e);
    chk_int("t6 rx byte count", rx_q.size() - q0, 12);

    // Randomized done pulses, gaps and occasional resets against the model.
    for (int ep = 0; ep < 25; ep++) begin
      int gap, rpos;
      ch0 = 8'($urandom); ch1 = 8'($urandom); ch2 = 8'($urandom); ch3 = 8'($urandom);
      pulse_done(int'($urandom_range(2, 12)));
      gap  = int'($urandom_range(2, 320));
      rpos = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, gap - 1)) : -1;
      for (int g = 0; g < gap; g++) begin
        RST = (g == rpos);
        step();
      end
      RST = 1'b0;
    end
    repeat (300) step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
